led_fade_trail: RTL and testbench
=================================

# led_fade_trail

Per-LED brightness fader placed directly downstream of the Knight Rider scanner. It turns the scanner's hard 8-bit on/off pattern into a fading "comet tail" on the physical LEDs. Each channel jumps to full brightness while its pattern bit is high, then decays one level per decay tick and is rendered with PWM. Outputs drive the board LEDs directly.

## Interface
- N, 8, number of LED channels
- L, 4, brightness level width; MAX = 2^L-1 (15)
- DECAY_M, 6250000, clocks per decay tick (≥ 2)
- clk  in  1  system clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- pattern  in  N  scanner pattern, one bit per LED, synchronous to clk
- leds  out  N  PWM-modulated LED drive, registered

## Operation
- Per-channel state: level[i], L bits, range 0..MAX.
- Decay counter: 0..DECAY_M-1, free-running, wraps to 0. tick = 1 for the one cycle where count == DECAY_M-1.
- PWM counter: L bits, counts 0..MAX-1 then wraps to 0. Period is MAX clocks (15). Free-running.
- Level update each clock, per channel, in priority order:
  - pattern[i] = 1 → level[i] <= MAX. Reload overrides a simultaneous tick.
  - else tick = 1 and level[i] > 0 → level[i] <= level[i] - 1.
  - else hold. Saturates at 0 and never wraps to MAX.
- Effective level eff[i]: equals level[i], except in gamma mode (see Configuration).
- leds[i] <= (eff[i] > pwm_cnt), registered.
  - eff = MAX gives constant 1.
  - eff = 0 gives constant 0.
  - Otherwise leds[i] is high for eff of every MAX cycles.
- Channels are independent. Any combination of pattern bits is legal, including all-ones and multiple-hot.

## Timing
- Reset (asynchronous):
  - all level[i] = 0
  - decay count = 0
  - pwm_cnt = 0
  - leds = 0, immediately, without waiting for a clock edge
- Release: the first update happens on the first rising edge with rst low.
- Mid-operation reset: the trail is lost, and leds read 0 throughout reset.
- pattern[i] rise → level = MAX at edge k+1 → leds[i] = 1 from edge k+2. Latency is 2 clocks.
- pattern[i] fall: the first decrement lands within 1..DECAY_M clocks, because the decay counter is not re-aligned.
- Full fade from MAX to 0 takes MAX ticks, i.e. between (MAX-1)·DECAY_M+1 and MAX·DECAY_M clocks.
- A pattern change within a PWM period takes effect on the next compare. No period alignment is required.

## Configuration
- Macro: LED_FADE_TRAIL_GAMMA_EN.
- Defined: eff[i] = (level[i]·level[i] + MAX) >> L, computed at 2L-bit width. For L = 4 this maps 0→0, 1→1, 8→4, 15→15, giving perceptually linear fading.
- Undefined: eff[i] = level[i], no multiplier logic.

## Test plan
Use DECAY_M = 4, L = 4, N = 8 unless noted.

- Reset behaviour: run with pattern = 8'hFF, assert rst between edges → leds = 8'h00 immediately, before the next clock edge. After release with pattern = 0, leds stay 0 indefinitely.
- Steady on: pattern = 8'h01 held → leds[0] = 1 from the 2nd edge after the change, with no gaps. leds[7:1] stay 0.
- Fade out: pattern = 8'h01 for 3 cycles, then 8'h00. The high-count of leds[0] per 15-cycle period must follow the level sequence:
  - without gamma: 14, 13, …, 1, 0
  - decreasing once every 4 clocks
  - leds[0] stays 0 after at most 60 clocks, and level never wraps back to 15.
- Reload priority: let level[3] decay to 5, then assert pattern[3] in the same cycle as a tick → level[3] = 15 next edge, and leds[3] is constant 1.
- Duty at level 8: freeze level at 8 (DECAY_M = 1000, pattern dropped, sample after 7 ticks) → 8 high per 15 cycles. With LED_FADE_TRAIL_GAMMA_EN defined → 4 high per 15 cycles.
- Scanner sweep: pattern walks 01→02→…→80→40…, one step per 8 clocks → the bit just left shows the highest duty and older bits show progressively lower duty. No channel ever exceeds level 15 or drops below 0.

Source files
------------

// File: rtl/led_fade_trail.sv
// led_fade_trail: per-LED fading comet tail with PWM output.
// Optional gamma mapping: define LED_FADE_TRAIL_GAMMA_EN.
module led_fade_trail #(
  parameter int N       = 8,
  parameter int L       = 4,
  parameter int DECAY_M = 6250000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pattern,
  output logic [N-1:0] leds
);

  localparam int MAX = (1 << L) - 1;
  localparam int CW  = (DECAY_M > 1) ? $clog2(DECAY_M) : 1;

  localparam logic [L-1:0]  MAXV  = L'(MAX);
  localparam logic [L-1:0]  PWM_T = L'(MAX - 1);
  localparam logic [CW-1:0] DC_T  = CW'(DECAY_M - 1);

  logic [CW-1:0] dcnt;
  logic          tick;
  logic [L-1:0]  pwm_cnt;
  logic [L-1:0]  level [N];
  logic [L-1:0]  eff   [N];

  assign tick = (dcnt == DC_T);

  // Free-running decay prescaler; tick marks its last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       dcnt <= '0;
    else if (tick) dcnt <= '0;
    else           dcnt <= dcnt + 1'b1;
  end

  // PWM phase counter, period MAX clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  pwm_cnt <= '0;
    else if (pwm_cnt == PWM_T) pwm_cnt <= '0;
    else                      pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Reload on pattern, otherwise decay by one on tick, floor at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) level[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (pattern[i])
          level[i] <= MAXV;
        else if (tick && level[i] != '0)
          level[i] <= level[i] - 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_ch
`ifdef LED_FADE_TRAIL_GAMMA_EN
    logic [2*L-1:0] sq;
    assign sq = ({{L{1'b0}}, level[g]} * {{L{1'b0}}, level[g]})
              + (2*L)'(MAX);
    assign eff[g] = L'(sq >> L);
`else
    assign eff[g] = level[g];
`endif
  end

  // Registered PWM compare per channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        leds[i] <= (eff[i] > pwm_cnt);
    end
  end

endmodule

// File: tb/tb_led_fade_trail.sv
// tb_led_fade_trail: vectors, corner sequences and a
// time-based reference model for led_fade_trail.
module tb_led_fade_trail;

  localparam int N   = 8;
  localparam int L   = 4;
  localparam int M   = 4;
  localparam int MAX = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] pattern = '0;
  logic [N-1:0] leds;
  logic [N-1:0] pattern_s = '0;
  logic [N-1:0] leds_s;

  always #5 clk = ~clk;

  led_fade_trail #(.N(N), .L(L), .DECAY_M(M)) dut (
    .clk(clk), .rst(rst), .pattern(pattern), .leds(leds)
  );

  led_fade_trail #(.N(N), .L(L), .DECAY_M(1000)) dut_slow (
    .clk(clk), .rst(rst), .pattern(pattern_s), .leds(leds_s)
  );

  int checks = 0;
  int errors = 0;
  int mlvl [N];
  int e;

  typedef struct {
    logic [7:0] pat;
    logic [7:0] exp1;
    logic [7:0] exp2;
  } vec_t;

  vec_t tbl [6];

  function automatic int effm(int l);
`ifdef LED_FADE_TRAIL_GAMMA_EN
    return (l * l + MAX) >> L;
`else
    return l;
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // One clock: brightness from elapsed time, pwm phase = e mod 15.
  task automatic step();
    logic [N-1:0] exp;
    bit t;
    t = ((e % M) == M - 1);
    for (int i = 0; i < N; i++)
      exp[i] = (effm(mlvl[i]) > (e % MAX));
    for (int i = 0; i < N; i++) begin
      if (pattern[i]) mlvl[i] = MAX;
      else if (t && mlvl[i] > 0) mlvl[i] = mlvl[i] - 1;
    end
    e++;
    @(posedge clk);
    #1;
    chk("model_leds", leds, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("reset_async", leds, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    e = 0;
    for (int i = 0; i < N; i++) mlvl[i] = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int last_on;
    int good;
    bit found;
    int pos;
    int dir;

    tbl[0] = '{8'h01, 8'h00, 8'h01};
    tbl[1] = '{8'h80, 8'h00, 8'h80};
    tbl[2] = '{8'hFF, 8'h00, 8'hFF};
    tbl[3] = '{8'hA5, 8'h00, 8'hA5};
    tbl[4] = '{8'h3C, 8'h00, 8'h3C};
    tbl[5] = '{8'h00, 8'h00, 8'h00};

    #1;
    chk("reset_initial", leds, 0);
    do_reset();

    // reset asserted between edges while all LEDs lit
    pattern = 8'hFF;
    repeat (5) step();
    chk("all_on_before_reset", leds, 8'hFF);
    #2;
    rst = 1'b1;
    #1;
    chk("reset_immediate", leds, 0);
    pattern = 8'h00;
    do_reset();
    good = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (leds == 0) good++;
    end
    chk("dark_after_release", good, 40);

    // table vectors: latency 2, then steady with no gaps
    for (int v = 0; v < 6; v++) begin
      pattern = 8'h00;
      do_reset();
      pattern = tbl[v].pat;
      step();
      chk("vec_edge1", leds, tbl[v].exp1);
      step();
      chk("vec_edge2", leds, tbl[v].exp2);
      good = 0;
      for (int k = 0; k < 20; k++) begin
        step();
        if (leds == tbl[v].pat) good++;
      end
      chk("vec_steady", good, 20);
    end

    // fade out of channel 0
    pattern = 8'h00;
    do_reset();
    pattern = 8'h01;
    repeat (3) step();
    pattern = 8'h00;
    hi = 0;
    last_on = -1;
    for (int k = 0; k < 100; k++) begin
      step();
      if (leds[0]) begin
        hi++;
        last_on = k;
      end
    end
    chk("fade_trail_present", hi >= 10, 1);
    chk("fade_done_60", last_on <= 60, 1);
    chk("fade_no_wrap", leds, 0);

    // reload on the same cycle as a tick
    do_reset();
    pattern = 8'h08;
    repeat (2) step();
    pattern = 8'h00;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (mlvl[3] == 5 && (e % M) == M - 1) found = 1;
      else step();
    end
    chk("reload_found", found, 1);
    pattern = 8'h08;
    step();
    pattern = 8'h00;
    good = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (leds[3]) good++;
    end
    chk("reload_full_on", good, 4);
    repeat (60) step();

    // scanner sweep, one position per 8 clocks
    do_reset();
    pos = 0;
    dir = 1;
    for (int s = 0; s < 80; s++) begin
      pattern = 8'(1 << pos);
      repeat (8) step();
      if (pos == 7) dir = -1;
      if (pos == 0) dir = 1;
      pos = pos + dir;
    end

    // random sparse patterns with occasional reset
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        pattern = 8'h00;
        do_reset();
      end
      if ($urandom_range(0, 3) == 0)
        pattern = 8'($urandom & $urandom & $urandom);
      step();
    end

    // duty at level 8 on the slow instance
    pattern = 8'h00;
    do_reset();
    pattern_s = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    pattern_s = 8'h00;
    repeat (7097) @(posedge clk);
    hi = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (leds_s[0]) hi++;
    end
    chk("duty_level8", hi, effm(8));
    chk("slow_others_off", leds_s[7:1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
